// File: rtl/mem_responder.sv
// mem_responder: serves the CPU icache/dcache ports from one valid/ready backing-memory port.
// Optional single-entry fetch buffer is built when MEM_RESPONDER_IBUF_EN is defined.
module mem_responder #(
  parameter int MEM_AW  = 30,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       icache_addr,
  input  logic              icache_re,
  output logic [31:0]       icache_dout,
  input  logic [31:0]       dcache_addr,
  input  logic              dcache_re,
  input  logic [3:0]        dcache_we,
  input  logic [31:0]       dcache_din,
  output logic [31:0]       dcache_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [MEM_AW-1:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              mem_err
);

  localparam int CW = (TIMEOUT > 32'sd255) ? $clog2(TIMEOUT + 32'sd1) : 32'sd8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 32'sd1);
  localparam bit WD_EN = (TIMEOUT != 32'sd0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    I_REQ  = 3'd3,
    I_WAIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [31:0]       icache_dout_r, dcache_dout_r, cap_data_s;
  logic              err_r, err_set_s;
  logic              d_cap_s, i_cap_s, d_wr_acc_s;
  logic              d_write_s, d_acc_s, req_s, ibuf_hit_s, timeout_s;
  logic [MEM_AW-1:0] i_word_s, d_word_s;

  assign d_write_s = (dcache_we != 4'h0);
  assign d_acc_s   = dcache_re | d_write_s;
  assign req_s     = icache_re | d_acc_s;
  assign i_word_s  = icache_addr[MEM_AW+1:2];
  assign d_word_s  = dcache_addr[MEM_AW+1:2];
  assign timeout_s = WD_EN && (cnt_r == TO_LAST);

`ifdef MEM_RESPONDER_IBUF_EN
  logic              ibuf_valid_r;
  logic [MEM_AW-1:0] ibuf_tag_r;

  // Last completed fetch word; a store to that word or a timed-out fetch invalidates it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ibuf_valid_r <= 1'b0;
      ibuf_tag_r   <= '0;
    end else if (i_cap_s) begin
      ibuf_valid_r <= ~err_set_s;
      ibuf_tag_r   <= i_word_s;
    end else if (d_wr_acc_s && (d_word_s == ibuf_tag_r)) begin
      ibuf_valid_r <= 1'b0;
    end else begin
      ibuf_valid_r <= ibuf_valid_r;
    end
  end

  assign ibuf_hit_s = icache_re & ~d_acc_s & ibuf_valid_r & (i_word_s == ibuf_tag_r);

  logic unused_s;
  assign unused_s = ^{icache_addr[1:0], dcache_addr[1:0]};
`else
  assign ibuf_hit_s = 1'b0;

  logic unused_s;
  assign unused_s = ^{icache_addr[1:0], dcache_addr[1:0], d_wr_acc_s};
`endif

  // Next-state, backing request fields and capture strobes.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    stall         = 1'b1;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = d_word_s;
    mem_req_data  = dcache_din;
    mem_req_mask  = 4'hF;
    cap_data_s    = mem_resp_data;
    d_cap_s       = 1'b0;
    i_cap_s       = 1'b0;
    err_set_s     = 1'b0;
    d_wr_acc_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && !ibuf_hit_s) begin
          state_s = d_acc_s ? D_REQ : I_REQ;
        end else begin
          stall = 1'b0;
        end
      end
      D_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = d_write_s;
        mem_req_mask  = d_write_s ? dcache_we : 4'hF;
        if (mem_req_ready) begin
          cnt_s = '0;
          if (d_write_s) begin
            // Stores are posted: no response is awaited.
            d_wr_acc_s = 1'b1;
            state_s    = icache_re ? I_REQ : DONE;
          end else begin
            state_s = D_WAIT;
          end
        end else begin
          state_s = D_REQ;
        end
      end
      D_WAIT: begin
        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (mem_resp_valid) begin
          d_cap_s = 1'b1;
          state_s = icache_re ? I_REQ : DONE;
        end else if (timeout_s) begin
          d_cap_s    = 1'b1;
          cap_data_s = 32'h0000_0000;
          err_set_s  = 1'b1;
          state_s    = icache_re ? I_REQ : DONE;
        end else begin
          state_s = D_WAIT;
        end
      end
      I_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = i_word_s;
        if (mem_req_ready) begin
          cnt_s   = '0;
          state_s = I_WAIT;
        end else begin
          state_s = I_REQ;
        end
      end
      I_WAIT: begin
        mem_req_addr = i_word_s;
        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (mem_resp_valid) begin
          i_cap_s = 1'b1;
          state_s = DONE;
        end else if (timeout_s) begin
          i_cap_s    = 1'b1;
          cap_data_s = 32'h0000_0000;
          err_set_s  = 1'b1;
          state_s    = DONE;
        end else begin
          state_s = I_WAIT;
        end
      end
      DONE: begin
        stall   = 1'b0;
        state_s = IDLE;
      end
      default: begin
        stall   = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, watchdog counter, captured read data and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      icache_dout_r <= 32'h0000_0000;
      dcache_dout_r <= 32'h0000_0000;
      err_r         <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (d_cap_s) begin
        dcache_dout_r <= cap_data_s;
      end else begin
        dcache_dout_r <= dcache_dout_r;
      end
      if (i_cap_s) begin
        icache_dout_r <= cap_data_s;
      end else begin
        icache_dout_r <= icache_dout_r;
      end
      err_r <= err_r | err_set_s;
    end
  end

  assign icache_dout = icache_dout_r;
  assign dcache_dout = dcache_dout_r;
  assign mem_err     = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: a word-level memory model predicts CPU read
// data and backing requests; independent monitors compare them against the DUT.
module tb_mem_responder;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   icache_addr, dcache_addr, dcache_din, icache_dout, dcache_dout;
  logic          icache_re, dcache_re, stall;
  logic [3:0]    dcache_we;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [31:0]   mem_req_data;
  logic [3:0]    mem_req_mask;
  logic          mem_resp_valid;
  logic [31:0]   mem_resp_data;
  logic          mem_err;

  mem_responder #(.MEM_AW(AW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] i; logic [31:0] d; logic err; } exp_t;
  typedef struct { logic rw; logic [AW-1:0] addr; logic [31:0] data; logic [3:0] mask; } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mreq_q[$];
  logic [31:0] ref_mem [logic [AW-1:0]];
  logic [31:0] bk_mem  [logic [AW-1:0]];
  logic [31:0] last_i = 32'h0, last_d = 32'h0;
  logic        err_exp = 1'b0;
  int          vec_cnt = 0, fail_cnt = 0;
  int          ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
  int          fixed_lat = 1;    // -1 picks a random latency per read
  bit          mute = 1'b0;      // backing memory never answers reads
  int          late_req = 0;

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bk_rd(input logic [AW-1:0] a);
    return bk_mem.exists(a) ? bk_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory: checks every presented request against the model, then serves it.
  initial begin : backing
    mreq_t       cur, e;
    bit          hs;
    int          resp_cnt, lat, late_done;
    logic [31:0] resp_data, w;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    resp_cnt = 0; late_done = 0; resp_data = 32'h0;
    forever begin
      @(negedge clk);
      cur.rw = mem_req_rw; cur.addr = mem_req_addr; cur.data = mem_req_data; cur.mask = mem_req_mask;
      hs = mem_req_valid && mem_req_ready && !reset;
      if (mem_req_valid && !reset) begin
        check("stall_while_req", 32'(stall), 32'd1);
        if (mreq_q.size() == 0) begin
          vec_cnt++; fail_cnt++;
          $display("FAIL unexpected_req: got addr %h rw %b expected no request", mem_req_addr, mem_req_rw);
        end else begin
          e = mreq_q[0];
          check("req_rw", 32'(cur.rw), 32'(e.rw));
          check("req_addr", 32'(cur.addr), 32'(e.addr));
          if (e.rw) begin
            check("req_data", cur.data, e.data);
            check("req_mask", 32'(cur.mask), 32'(e.mask));
          end
          if (hs) void'(mreq_q.pop_front());
        end
      end
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (reset) resp_cnt = 0;
      else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin mem_resp_valid = 1'b1; mem_resp_data = resp_data; end
      end
      if (hs) begin
        if (cur.rw) begin
          w = bk_rd(cur.addr);
          for (int b = 0; b < 4; b++) if (cur.mask[b]) w[8*b +: 8] = cur.data[8*b +: 8];
          bk_mem[cur.addr] = w;
        end else if (!mute) begin
          lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 2);
          resp_data = bk_rd(cur.addr);
          if (lat == 0) begin mem_resp_valid = 1'b1; mem_resp_data = resp_data; end
          else resp_cnt = lat;
        end
      end
      if (late_req != late_done) begin
        late_done = late_req; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
      end
      mem_req_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // CPU-side monitor: one cycle after a request sees stall low, both douts and mem_err are checked.
  initial begin : cpu_mon
    bit   pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          vec_cnt++; fail_cnt++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          e = exp_q.pop_front();
          check("icache_dout", icache_dout, e.i);
          check("dcache_dout", dcache_dout, e.d);
          check("mem_err", 32'(mem_err), 32'(e.err));
        end
      end
      pend = !reset && !stall && (icache_re || dcache_re || (dcache_we != 4'h0));
    end
  end

  task automatic do_txn(input bit ir, input logic [31:0] ia, input bit dr, input logic [3:0] we,
                        input logic [31:0] da, input logic [31:0] din, output int stall_cyc);
    mreq_t       m;
    logic [31:0] w;
    bit          done;
    @(posedge clk); #1;
    icache_re = ir; icache_addr = ia; dcache_re = dr; dcache_we = we;
    dcache_addr = da; dcache_din = din;
    if (we != 4'h0) begin
      m.rw = 1'b1; m.addr = da[31:2]; m.data = din; m.mask = we; mreq_q.push_back(m);
      w = ref_rd(da[31:2]);
      for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = din[8*b +: 8];
      ref_mem[da[31:2]] = w;
    end else if (dr) begin
      m.rw = 1'b0; m.addr = da[31:2]; m.data = 32'h0; m.mask = 4'hF; mreq_q.push_back(m);
      if (mute) begin last_d = 32'h0; err_exp = 1'b1; end
      else last_d = ref_rd(da[31:2]);
    end
    if (ir) begin
      m.rw = 1'b0; m.addr = ia[31:2]; m.data = 32'h0; m.mask = 4'hF; mreq_q.push_back(m);
      if (mute) begin last_i = 32'h0; err_exp = 1'b1; end
      else last_i = ref_rd(ia[31:2]);
    end
    exp_q.push_back('{last_i, last_d, err_exp});
    stall_cyc = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (stall) stall_cyc++;
      else done = 1'b1;
    end
    if (!done) begin
      vec_cnt++; fail_cnt++;
      $display("FAIL stall_release: got stall held 64 cycles expected release");
    end
    @(posedge clk); #1;
    icache_re = 1'b0; dcache_re = 1'b0; dcache_we = 4'h0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int          sc, k;
    bit          ir, dr;
    logic [3:0]  we;
    reset = 1'b1; icache_re = 1'b0; dcache_re = 1'b0; dcache_we = 4'h0;
    icache_addr = 32'h0; dcache_addr = 32'h0; dcache_din = 32'h0;
    ref_mem[30'h800] = 32'h0000_0013; bk_mem[30'h800] = 32'h0000_0013;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_icache_dout", icache_dout, 32'h0);
    check("rst_dcache_dout", dcache_dout, 32'h0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    do_txn(1'b1, 32'h2000, 1'b0, 4'h0, 32'h0, 32'h0, sc);
    check("fetch_stall_cycles", 32'(sc), 32'd4);
    do_txn(1'b1, 32'h2004, 1'b1, 4'h0, 32'h1004, 32'h0, sc);
    check("load_fetch_stall_cycles", 32'(sc), 32'd7);
    do_txn(1'b0, 32'h0, 1'b0, 4'b0100, 32'h1006, 32'h00AB_0000, sc);
    check("store_stall_cycles", 32'(sc), 32'd2);

    @(negedge clk); ready_mode = 2;
    fork
      do_txn(1'b0, 32'h0, 1'b0, 4'hF, 32'h1008, 32'h1234_5678, sc);
      begin repeat (6) @(negedge clk); ready_mode = 1; end
    join
    check("backpressure_stall_cycles", 32'(sc), 32'd7);

    @(negedge clk); mute = 1'b1;
    do_txn(1'b1, 32'h2008, 1'b0, 4'h0, 32'h0, 32'h0, sc);
    check("timeout_stall_cycles", 32'(sc), 32'd6);
    do_txn(1'b1, 32'h200C, 1'b1, 4'h0, 32'h100C, 32'h0, sc);
    check("timeout_load_fetch_cycles", 32'(sc), 32'd11);

    @(negedge clk); mute = 1'b0; fixed_lat = -1; ready_mode = 0;
    for (int n = 0; n < 150; n++) begin
      k  = $urandom_range(0, 7);
      ir = k[0]; dr = k[1];
      we = k[2] ? 4'($urandom_range(1, 15)) : 4'h0;
      if (!ir && !dr && (we == 4'h0)) ir = 1'b1;
      do_txn(ir, 32'h1000 | 32'($urandom_range(0, 63)), dr, we,
             32'h1000 | 32'($urandom_range(0, 63)), $urandom, sc);
    end

    @(negedge clk); mute = 1'b1; ready_mode = 1;
    @(posedge clk); #1;
    dcache_re = 1'b1; dcache_addr = 32'h1010;
    mreq_q.push_back('{1'b0, 30'h404, 32'h0, 4'hF});
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1; dcache_re = 1'b0;
    last_i = 32'h0; last_d = 32'h0; err_exp = 1'b0;
    @(negedge clk);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_req_valid", 32'(mem_req_valid), 32'd0);
    check("midrst_icache_dout", icache_dout, 32'h0);
    check("midrst_dcache_dout", dcache_dout, 32'h0);
    check("midrst_mem_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1; reset = 1'b0; late_req++;
    repeat (3) @(negedge clk);
    check("late_resp_dcache_dout", dcache_dout, 32'h0);
    check("late_resp_icache_dout", icache_dout, 32'h0);
    check("late_resp_stall", 32'(stall), 32'd0);
    mute = 1'b0; fixed_lat = 1;
    do_txn(1'b1, 32'h2010, 1'b1, 4'h0, 32'h1014, 32'h0, sc);
    check("post_rst_stall_cycles", 32'(sc), 32'd7);

    repeat (2) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("mreq_q_drained", 32'(mreq_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
